// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: BOOT/FETCH/WAIT request sequencer with delay-slot branch handling.
// Optional macro FETCH_CTRL_ALIGN_EXC_EN adds a misaligned-jr trap (exc_adel output).
module fetch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        d_valid,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_pc,
  input  logic [25:0] d_imm,
  input  logic [31:0] d_rs,
  input  logic        d_zero,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic        i_gnt,
  input  logic        i_rvalid,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic        redirect
`ifdef FETCH_CTRL_ALIGN_EXC_EN
  ,
  output logic        exc_adel
`endif
);

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [2:0]  OP_BEQ     = 3'b001;
  localparam logic [2:0]  OP_J       = 3'b010;
  localparam logic [2:0]  OP_JR      = 3'b011;
`ifdef FETCH_CTRL_ALIGN_EXC_EN
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
`endif

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issued_q, issued_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        redirect_q, redirect_d;
  logic        exc_q, exc_d;

  logic        taken;
  logic        misaligned;
  logic [31:0] beq_off;
  logic [31:0] target_raw;
  logic [31:0] target;

  // Decode the D-stage control transfer and its 32-bit (wrapping) target.
  always_comb begin
    taken      = 1'b0;
    target_raw = '0;
    misaligned = 1'b0;
    beq_off    = {{14{d_imm[15]}}, d_imm[15:0], 2'b00};
    case (d_op)
      OP_BEQ: begin
        taken      = d_valid && d_zero;
        target_raw = d_pc + 32'd4 + beq_off;
      end
      OP_J: begin
        taken      = d_valid;
        target_raw = {d_pc[31:28], d_imm, 2'b00};
      end
      OP_JR: begin
        taken      = d_valid;
        target_raw = d_rs;
        misaligned = (d_rs[1:0] != 2'b00);
      end
      default: begin
        taken      = 1'b0;
        target_raw = '0;
      end
    endcase
`ifdef FETCH_CTRL_ALIGN_EXC_EN
    target = misaligned ? EXC_VECTOR : target_raw;
`else
    target = target_raw & ~32'h3;
`endif
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issued_d     = issued_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    f_valid_d    = 1'b0;
    f_pc_d       = f_pc_q;
    redirect_d   = taken;
    exc_d        = taken && misaligned;
    i_req        = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (taken) pc_d = target;
      end
      S_FETCH: begin
        i_req = !stall;
        if (!stall && i_gnt) begin
          // The old pc is already on the bus, so a same-cycle transfer is the delay slot.
          issued_d = pc_q;
          state_d  = S_WAIT;
          if (taken) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = target;
          end
        end else if (taken) begin
          pc_d = target;
        end
      end
      S_WAIT: begin
        if (i_rvalid) begin
          f_valid_d    = 1'b1;
          f_pc_d       = issued_q;
          state_d      = S_FETCH;
          pend_valid_d = 1'b0;
          if (taken)             pc_d = target;
          else if (pend_valid_q) pc_d = pend_tgt_q;
          else                   pc_d = issued_q + 32'd4;
        end else if (taken) begin
          pend_valid_d = 1'b1;
          pend_tgt_d   = target;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      issued_q     <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= RESET_PC;
      f_valid_q    <= 1'b0;
      f_pc_q       <= RESET_PC;
      redirect_q   <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issued_q     <= issued_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      f_valid_q    <= f_valid_d;
      f_pc_q       <= f_pc_d;
      redirect_q   <= redirect_d;
      exc_q        <= exc_d;
    end
  end

  assign i_addr   = pc_q;
  assign f_valid  = f_valid_q;
  assign f_pc     = f_pc_q;
  assign redirect = redirect_q;

`ifdef FETCH_CTRL_ALIGN_EXC_EN
  assign exc_adel = exc_q;
`else
  logic unused_exc;
  assign unused_exc = exc_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1 bit: downstream hazard stall; blocks new fetch requests.
REQ-004 SHALL have port d_valid, input, 1 bit: the D-stage control-transfer fields are valid this cycle.
REQ-005 SHALL have port d_op, input, 3 bits: 000 sequential, 001 beq, 010 j/jal, 011 jr; other codes are treated as sequential.
REQ-006 SHALL have ports d_pc (input, 32 bits), d_imm (input, 26 bits), d_rs (input, 32 bits) and d_zero (input, 1 bit): D-stage PC, immediate field, jr register value and comparator result.
REQ-007 SHALL have ports i_req (output, 1 bit), i_addr (output, 32 bits) and i_gnt (input, 1 bit): the instruction-memory request handshake.
REQ-008 SHALL have port i_rvalid, input, 1 bit: instruction-memory response; at most one response per granted request, arriving 1 or more cycles after the grant.
REQ-009 SHALL have ports f_valid (output, 1 bit) and f_pc (output, 32 bits): registered fetch completion pulse and the PC of the returned instruction.
REQ-010 SHALL have port redirect, output, 1 bit: registered flag, high for one cycle after a taken transfer is accepted.

Function
REQ-011 SHALL define taken as d_valid AND (op 001 with d_zero=1, OR op 010, OR op 011).
REQ-012 SHALL compute the transfer target as: beq = d_pc + 4 + (sign-extended d_imm[15:0] shifted left 2); j = {d_pc[31:28], d_imm, 2'b00}; jr = d_rs. All arithmetic is 32-bit and wraps modulo 2^32.
REQ-013 SHALL implement the states BOOT, FETCH and WAIT.
REQ-014 SHALL leave BOOT for FETCH unconditionally after one cycle, with i_req=0 throughout BOOT.
REQ-015 SHALL drive, in FETCH, i_req = !stall and i_addr = pc; a cycle with i_req AND i_gnt SHALL capture pc as the issued address and move to WAIT.
REQ-016 SHALL hold i_req=0 in WAIT; on i_rvalid it SHALL set f_valid=1 and f_pc=issued address on the next edge, update pc, and return to FETCH.
REQ-017 SHALL update pc on response to the first of the following that applies: a same-cycle taken target, else the pending target, else issued address + 4; pending is cleared on use.
REQ-018 SHALL handle a taken transfer in FETCH or BOOT without a grant that cycle by loading pc with the target directly.
REQ-019 SHALL handle a taken transfer in FETCH with a same-cycle grant by issuing the old pc and storing the target as pending (delay-slot semantics).
REQ-020 SHALL handle a taken transfer in WAIT by storing the target as pending; a newer taken transfer overwrites any older pending target.
REQ-021 SHALL keep the state unchanged while stall is high; stall SHALL NOT cancel an outstanding request, and i_rvalid during stall is still accepted.
REQ-022 SHALL pulse f_valid for exactly one cycle per response and never without a prior grant.

Reset
REQ-023 SHALL, on reset, asynchronously set pc=0x0000_3000, state=BOOT, pending invalid, f_valid=0, f_pc=0x0000_3000, redirect=0 and i_req=0; a reset mid-request discards the outstanding response.

Configuration
REQ-024 SHALL use macro FETCH_CTRL_ALIGN_EXC_EN: when defined, a jr target with nonzero bits [1:0] is replaced by 0x0000_4180 and output exc_adel (1 bit, registered, reset 0) pulses for one cycle; when undefined, target bits [1:0] are forced to 00 and port exc_adel does not exist.

Verification
REQ-025 Reset release, i_gnt=1, response 1 cycle later -> i_addr sequence 0x3000, 0x3004, 0x3008; f_pc follows one response behind.
REQ-026 beq with d_pc=0x3010, imm=0xFFFF, d_zero=1, issued in FETCH without grant -> next i_addr 0x3010; with d_zero=0 -> no redirect.
REQ-027 j with d_imm=0x0000C10, asserted in WAIT -> the current response completes, then i_addr=0x0000_3040.
REQ-028 stall held 5 cycles in FETCH -> i_req stays 0 and pc is unchanged; the fetch resumes on the next cycle after stall drops.
REQ-029 jr with d_rs=0x3002 -> with the macro defined, i_addr=0x4180 and exc_adel pulses; with the macro undefined, i_addr=0x3000.
REQ-030 reset asserted in WAIT with a response pending -> a late i_rvalid produces no f_valid, and the first request after BOOT is 0x3000.
